// File: rtl/rr_sel_arbiter_4_pkg.sv
// Shared definitions for the 4-channel round-robin select arbiter.
// Holds the FSM state encoding and channel/select sizing used by the top and the picker.
package rr_sel_arbiter_4_pkg;

  localparam int NUM_CH = 4;
  localparam int SEL_W  = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

endpackage

// File: rtl/rr_pick_4.sv
// Combinational round-robin picker: searches last+1, last+2, last+3, last and returns
// the first requesting channel as a one-hot vector and a binary index.
module rr_pick_4
  import rr_sel_arbiter_4_pkg::*;
(
  input  logic [NUM_CH-1:0] req,
  input  logic [SEL_W-1:0]  last,
  output logic [NUM_CH-1:0] winner,
  output logic [SEL_W-1:0]  winner_idx,
  output logic              any
);

  // Walk from lowest to highest priority so the highest-priority hit is written last.
  always_comb begin
    logic [SEL_W-1:0] idx;
    idx        = '0;
    winner     = '0;
    winner_idx = '0;
    any        = 1'b0;
    for (int k = NUM_CH; k >= 1; k--) begin
      idx = last + SEL_W'(k);
      if (req[idx]) begin
        winner      = '0;
        winner[idx] = 1'b1;
        winner_idx  = idx;
        any         = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_sel_arbiter_4.sv
// Four-channel round-robin arbiter driving a registered 4:1 mux select with a valid/ready
// handshake; each grant lasts until its request drops or MAX_HOLD transfers are accepted.
module rr_sel_arbiter_4
  import rr_sel_arbiter_4_pkg::*;
#(
  parameter int MAX_HOLD = 4,
  parameter int CNT_W    = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] req,
  input  logic              ready,
  output logic [NUM_CH-1:0] gnt,
  output logic [SEL_W-1:0]  sel,
  output logic              valid,
  output logic              xfer
);

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  hold_q, hold_d;
  logic [SEL_W-1:0]  last_q, last_d;
  logic [NUM_CH-1:0] gnt_d;
  logic [SEL_W-1:0]  sel_d;
  logic              valid_d;

  logic [SEL_W-1:0]  pick_last;
  logic [NUM_CH-1:0] winner;
  logic [SEL_W-1:0]  winner_idx;
  logic              any;
  logic              release_grant;

  assign xfer = valid & ready;

  // On release the current channel becomes the lowest priority in the same cycle.
  assign pick_last     = (state_q == GRANT) ? sel : last_q;
  assign release_grant = (state_q == GRANT) &&
                         (!req[sel] || (xfer && (hold_q == HOLD_LAST)));

  rr_pick_4 u_pick (
    .req        (req),
    .last       (pick_last),
    .winner     (winner),
    .winner_idx (winner_idx),
    .any        (any)
  );

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    last_d  = last_q;
    gnt_d   = gnt;
    sel_d   = sel;
    valid_d = valid;
    case (state_q)
      IDLE: begin
        if (any) begin
          state_d = GRANT;
          gnt_d   = winner;
          sel_d   = winner_idx;
          valid_d = 1'b1;
          hold_d  = '0;
        end
      end
      GRANT: begin
        if (release_grant) begin
          last_d = sel;
          hold_d = '0;
          if (any) begin
            gnt_d   = winner;
            sel_d   = winner_idx;
            valid_d = 1'b1;
          end else begin
            state_d = IDLE;
            gnt_d   = '0;
            sel_d   = '0;
            valid_d = 1'b0;
          end
        end else if (xfer) begin
          hold_d = hold_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
        sel_d   = '0;
        valid_d = 1'b0;
        hold_d  = '0;
      end
    endcase
  end

  // last resets to 3 so channel 0 is searched first after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      hold_q  <= '0;
      last_q  <= 2'd3;
      gnt     <= '0;
      sel     <= '0;
      valid   <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      last_q  <= last_d;
      gnt     <= gnt_d;
      sel     <= sel_d;
      valid   <= valid_d;
    end
  end

endmodule
